// File: rtl/display_timing.sv
// Raster timing generator with a valid/ready pixel sink.
// Counters walk each line and frame as active, front porch, sync, back porch.
// The visible outputs are registered one cycle behind the counters.
// Handshake: pix_ready is combinational from state and counters only, never from pix_valid.
// A pixel moves on every cycle where pix_ready and pix_valid are both high.
// A cycle with pix_ready high and pix_valid low is a starved pixel: it is shown black and sets underflow.
module display_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DW       = 24,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [DW-1:0] rgb,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          underflow
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_hcnt;
  logic [YW-1:0] r_vcnt;
  logic          w_h_wrap;
  logic          w_frame_wrap;
  logic          w_in_active;
  logic          w_xfer;

  assign w_h_wrap     = (r_hcnt == H_LAST);
  assign w_frame_wrap = w_h_wrap && (r_vcnt == V_LAST);
  assign w_in_active  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  // Reset pulls ready down immediately, not one cycle late.
  assign pix_ready    = !reset && (r_state != IDLE) && w_in_active;
  assign w_xfer       = pix_ready && pix_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  // DRAIN only returns to IDLE on the frame wrap, so a frame is never cut short.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en)                w_state_nxt = RUN;
        else if (w_frame_wrap) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Raster counters: parked at (0,0) in IDLE, free-running otherwise.
  always_ff @(posedge clk) begin
    if (reset || r_state == IDLE) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_wrap) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Registered video outputs, all aligned one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (reset || r_state == IDLE) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      rgb         <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (r_hcnt >= HS_START && r_hcnt < HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (r_vcnt >= VS_START && r_vcnt < VS_END) ? VS_POL : ~VS_POL;
      de          <= pix_ready;
      rgb         <= w_xfer ? pix_data : '0;
      x           <= r_hcnt;
      y           <= r_vcnt;
      frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  // Sticky starvation flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                         underflow <= 1'b0;
    else if (pix_ready && !pix_valid)  underflow <= 1'b1;
  end

endmodule
